// File: rtl/sdio_seq_pkg.sv
// Shared constants for the SD card bring-up sequencer: control-port register map,
// CMD-register bit layout, response-type codes and abort causes.
package sdio_seq_pkg;

    localparam logic [2:0] ADDR_CMD = 3'd0;
    localparam logic [2:0] ADDR_ARG = 3'd1;
    localparam logic [2:0] ADDR_PHY = 3'd4;

    localparam int CMD_BUSY_BIT = 14;
    localparam int CMD_ERR_BIT  = 15;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R1     = 2'd1,
        R2     = 2'd2,
        R1b    = 2'd3
    } resp_t;

    // R3/R6/R7 are all 48-bit short responses, same framing as R1
    localparam resp_t R3 = R1;
    localparam resp_t R6 = R1;
    localparam resp_t R7 = R1;

    typedef enum logic [3:0] {
        ERR_NONE      = 4'h0,
        ERR_WB        = 4'h1,
        ERR_TIMEOUT   = 4'h2,
        ERR_CMD       = 4'h3,
        ERR_ECHO      = 4'h4,
        ERR_NOT_READY = 4'h5,
        ERR_RCA       = 4'h6
    } err_code_t;

    function automatic logic [31:0] cmd_word(input resp_t rt, input logic [5:0] idx);
        return {22'd0, rt, 2'b01, idx};
    endfunction

endpackage

// File: rtl/sdio_init_seq_if.sv
// Wishbone link between the bring-up sequencer (master) and sdio_top's control port.
interface sdio_init_seq_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output cyc, stb, we, addr, wdata, sel, input stall, ack, err, rdata);
    modport slave  (input cyc, stb, we, addr, wdata, sel, output stall, ack, err, rdata);
endinterface

// File: rtl/sdio_wb_xfer.sv
// Single-transaction Wishbone master: req launches one cycle, done/err pulse the cycle cyc drops.
// Holds stb through i_wb_stall; req is only honoured while the bus is idle.
module sdio_wb_xfer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    sdio_init_seq_if.master wb
);

    assign wb.sel = 4'hf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb.cyc   <= 1'b0;
            wb.stb   <= 1'b0;
            wb.we    <= 1'b0;
            wb.addr  <= '0;
            wb.wdata <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (!wb.cyc) begin
                if (req) begin
                    wb.cyc   <= 1'b1;
                    wb.stb   <= 1'b1;
                    wb.we    <= we;
                    wb.addr  <= addr;
                    wb.wdata <= wdata;
                end
            end else begin
                if (wb.stb && !wb.stall)
                    wb.stb <= 1'b0;
                if (wb.ack || wb.err) begin
                    wb.cyc <= 1'b0;
                    wb.stb <= 1'b0;
                    done   <= 1'b1;
                    err    <= wb.err;
                    rdata  <= wb.rdata;
                end
            end
        end
    end

endmodule

// File: rtl/sdio_init_seq.sv
// Card bring-up sequencer: PHY slow, CMD0/8/(55+41)*/2/3/7, PHY fast; reports RCA/OCR.
// Each command is ARG write, CMD write, CMD polls until not busy, then an ARG read.
module sdio_init_seq
    import sdio_seq_pkg::*;
#(
    parameter int          LGTIMEOUT  = 20,
    parameter int          MAX_ACMD41 = 1000,
    parameter logic [31:0] PHY_SLOW   = 32'h0000_00fc,
    parameter logic [31:0] PHY_FAST   = 32'h0000_0102
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [3:0]  o_err_code,
    output logic [15:0] o_rca,
    output logic [31:0] o_ocr,
    sdio_init_seq_if.master wb
);

    localparam int ACW = $clog2(MAX_ACMD41 + 1);

    // Encoded in sequence order so the normal advance is state + 1
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PHY_SLOW = 4'd1;
    localparam logic [3:0] S_CMD0     = 4'd2;
    localparam logic [3:0] S_CMD8     = 4'd3;
    localparam logic [3:0] S_CMD55    = 4'd4;
    localparam logic [3:0] S_ACMD41   = 4'd5;
    localparam logic [3:0] S_CMD2     = 4'd6;
    localparam logic [3:0] S_CMD3     = 4'd7;
    localparam logic [3:0] S_CMD7     = 4'd8;
    localparam logic [3:0] S_PHY_FAST = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;
    localparam logic [3:0] S_ERROR    = 4'd11;

    localparam logic [1:0] P_ARG  = 2'd0;
    localparam logic [1:0] P_CMD  = 2'd1;
    localparam logic [1:0] P_POLL = 2'd2;
    localparam logic [1:0] P_RSP  = 2'd3;

    logic [3:0]           state;
    logic [1:0]           phase;
    logic                 pend;
    logic [LGTIMEOUT-1:0] poll_cnt;
    logic [ACW-1:0]       acmd_cnt;
    logic [ACW-1:0]       acmd_nxt;

    logic        x_req, x_we, x_done, x_err, is_phy;
    logic [2:0]  x_addr;
    logic [31:0] x_wdata, x_rdata;
    logic [5:0]  cmd_idx;
    resp_t       cmd_rt;
    logic [31:0] cmd_arg;

    always_comb begin
        cmd_idx = 6'd0;
        cmd_rt  = R_NONE;
        cmd_arg = 32'h0;
        case (state)
            S_CMD8:   begin cmd_idx = 6'd8;  cmd_rt = R7;  cmd_arg = 32'h0000_01AA; end
            S_CMD55:  begin cmd_idx = 6'd55; cmd_rt = R1;  end
            S_ACMD41: begin cmd_idx = 6'd41; cmd_rt = R3;  cmd_arg = 32'h40FF_8000; end
            S_CMD2:   begin cmd_idx = 6'd2;  cmd_rt = R2;  end
            S_CMD3:   begin cmd_idx = 6'd3;  cmd_rt = R6;  end
            S_CMD7:   begin cmd_idx = 6'd7;  cmd_rt = R1b; cmd_arg = {o_rca, 16'h0}; end
            default:  ;
        endcase
    end

    assign o_busy   = (state != S_IDLE);
    assign o_done   = (state == S_DONE);
    assign o_err    = (state == S_ERROR);
    assign is_phy   = (state == S_PHY_SLOW) || (state == S_PHY_FAST);
    assign acmd_nxt = acmd_cnt + 1'b1;

    assign x_req   = o_busy && !o_done && !o_err && !pend;
    assign x_we    = is_phy || (phase == P_ARG) || (phase == P_CMD);
    assign x_addr  = is_phy ? ADDR_PHY :
                     ((phase == P_CMD) || (phase == P_POLL)) ? ADDR_CMD : ADDR_ARG;
    assign x_wdata = is_phy ? ((state == S_PHY_SLOW) ? PHY_SLOW : PHY_FAST) :
                     (phase == P_ARG) ? cmd_arg : cmd_word(cmd_rt, cmd_idx);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase      <= P_ARG;
            pend       <= 1'b0;
            poll_cnt   <= '0;
            acmd_cnt   <= '0;
            o_err_code <= '0;
            o_rca      <= '0;
            o_ocr      <= '0;
        end else begin
            if (x_req)
                pend <= 1'b1;
            case (state)
                S_IDLE: if (i_start) begin
                    state      <= S_PHY_SLOW;
                    phase      <= P_ARG;
                    acmd_cnt   <= '0;
                    o_err_code <= ERR_NONE;
                end
                S_DONE, S_ERROR: state <= S_IDLE;
                default: if (x_done) begin
                    pend <= 1'b0;
                    if (x_err) begin
                        state <= S_ERROR; o_err_code <= ERR_WB;
                    end else if (is_phy) begin
                        state <= state + 4'd1;
                    end else begin
                        case (phase)
                            P_ARG: phase <= P_CMD;
                            P_CMD: begin phase <= P_POLL; poll_cnt <= '0; end
                            P_POLL: begin
                                if (x_rdata[CMD_BUSY_BIT]) begin
                                    if (&poll_cnt) begin
                                        state <= S_ERROR; o_err_code <= ERR_TIMEOUT;
                                    end else
                                        poll_cnt <= poll_cnt + 1'b1;
                                end else if (x_rdata[CMD_ERR_BIT] && state != S_CMD8) begin
                                    state <= S_ERROR; o_err_code <= ERR_CMD;
                                // CMD8 error means a v1 card: no echo to check
                                end else if (cmd_rt == R_NONE || x_rdata[CMD_ERR_BIT]) begin
                                    state <= state + 4'd1; phase <= P_ARG;
                                end else
                                    phase <= P_RSP;
                            end
                            default: begin
                                phase <= P_ARG;
                                case (state)
                                    S_CMD8: if (x_rdata[11:0] != 12'h1AA) begin
                                        state <= S_ERROR; o_err_code <= ERR_ECHO;
                                    end else
                                        state <= state + 4'd1;
                                    S_ACMD41: begin
                                        o_ocr <= x_rdata;
                                        if (x_rdata[31])
                                            state <= state + 4'd1;
                                        else if (acmd_nxt == ACW'(MAX_ACMD41)) begin
                                            state <= S_ERROR; o_err_code <= ERR_NOT_READY;
                                        end else begin
                                            acmd_cnt <= acmd_nxt;
                                            state    <= S_CMD55;
                                        end
                                    end
                                    S_CMD3: begin
                                        o_rca <= x_rdata[31:16];
                                        if (x_rdata[31:16] == 16'h0) begin
                                            state <= S_ERROR; o_err_code <= ERR_RCA;
                                        end else
                                            state <= state + 4'd1;
                                    end
                                    default: state <= state + 4'd1;
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    sdio_wb_xfer u_xfer (
        .clk   (clk),
        .reset (reset),
        .req   (x_req),
        .we    (x_we),
        .addr  (x_addr),
        .wdata (x_wdata),
        .done  (x_done),
        .err   (x_err),
        .rdata (x_rdata),
        .wb    (wb)
    );

endmodule

// File: tb/tb_sdio_init_seq.sv
// Directed bench: bring-up sequencer against a behavioural sdio_top/card stand-in on the WB port.
module tb_sdio_init_seq;

    localparam logic [31:0] PHY_SLOW_V = 32'h0000_00fc;
    localparam logic [31:0] PHY_FAST_V = 32'h0000_0102;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, i_start;
    logic        o_busy, o_done, o_err;
    logic [3:0]  o_err_code;
    logic [15:0] o_rca;
    logic [31:0] o_ocr;

    sdio_init_seq_if bus ();

    sdio_init_seq #(.LGTIMEOUT(4), .MAX_ACMD41(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .o_rca      (o_rca),
        .o_ocr      (o_ocr),
        .wb         (bus)
    );

    int checks = 0;
    int failures = 0;

    // card configuration, written only by the stimulus
    int          busy_polls  = 1;
    bit          card_absent = 1'b0;
    bit          v1_card     = 1'b0;
    int          acmd_busy   = 0;
    int          acmd_base   = 0;
    logic [11:0] echo        = 12'h1AA;
    logic [15:0] card_rca    = 16'h1234;
    int          err_at      = 0;
    bit          stall_en    = 1'b0;

    // slave/card state, written only by the model
    int          xfer_cnt = 0, cmd55_cnt = 0, acmd41_cnt = 0, slow_cnt = 0, fast_cnt = 0;
    int          done_cnt = 0, stb_no_cyc = 0, busy_left = 0;
    logic [5:0]  cur_idx    = 6'd0;
    logic [2:0]  last_waddr = 3'd0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] rd_next    = 32'h0;
    bit          pend = 1'b0, err_next = 1'b0;

    always @(negedge clk) begin
        bus.ack = 1'b0;
        bus.err = 1'b0;
        if (o_done) done_cnt++;
        if (bus.stb && !bus.cyc) stb_no_cyc++;
        if (!bus.cyc) pend = 1'b0;
        if (pend) begin
            pend      = 1'b0;
            bus.ack   = !err_next;
            bus.err   = err_next;
            bus.rdata = rd_next;
        end
        bus.stall = stall_en && bus.cyc && bus.stb && !bus.stall;
        if (bus.cyc && bus.stb && !bus.stall) begin
            xfer_cnt++;
            err_next = (xfer_cnt == err_at);
            rd_next  = 32'h0;
            pend     = 1'b1;
            if (bus.we) begin
                last_waddr = bus.addr;
                last_wdata = bus.wdata;
                if (bus.addr == 3'd0) begin
                    cur_idx   = bus.wdata[5:0];
                    busy_left = (card_absent && cur_idx != 6'd0) ? 1000 : busy_polls;
                    if (cur_idx == 6'd55) cmd55_cnt++;
                    if (cur_idx == 6'd41) acmd41_cnt++;
                end else if (bus.addr == 3'd4) begin
                    if (bus.wdata == PHY_SLOW_V) slow_cnt++;
                    if (bus.wdata == PHY_FAST_V) fast_cnt++;
                end
            end else if (bus.addr == 3'd0) begin
                rd_next[14] = (busy_left > 0);
                rd_next[15] = (busy_left == 0) && v1_card && (cur_idx == 6'd8);
                if (busy_left > 0) busy_left--;
            end else if (bus.addr == 3'd1) begin
                case (cur_idx)
                    6'd8:    rd_next = {20'h0, echo};
                    6'd41:   rd_next = (acmd41_cnt - acmd_base <= acmd_busy) ? 32'h00FF_8000 : 32'hC0FF_8000;
                    6'd3:    rd_next = {card_rca, 16'h0500};
                    default: rd_next = 32'h0000_0900;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input bit extra, output bit got_done, output bit got_err);
        int n = 0;
        acmd_base = acmd41_cnt;
        got_done  = 1'b0;
        got_err   = 1'b0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        chk("start_busy", o_busy, 1);
        chk("start_code_clr", o_err_code, 0);
        while (!got_done && !got_err && n < 3000) begin
            @(negedge clk);
            n++;
            got_done = o_done;
            got_err  = o_err;
            i_start  = extra && (n % 25 == 0);
        end
        i_start = 1'b0;
        chk("run_bound", n < 3000, 1);
    endtask

    initial begin
        bit d, e;
        int b0, c0, a0, s0, f0, d0, n;
        reset   = 1'b0;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_cyc", bus.cyc, 0);
        chk("rst_stb", bus.stb, 0);
        chk("rst_code", o_err_code, 0);
        chk("rst_rca", o_rca, 0);
        chk("rst_ocr", o_ocr, 0);
        chk("rst_sel", bus.sel, 4'hf);
        reset = 1'b1;

        // nominal, slave stalls every strobe once
        stall_en = 1'b1;
        b0 = xfer_cnt; c0 = cmd55_cnt; s0 = slow_cnt; f0 = fast_cnt;
        run(1'b0, d, e);
        chk("nom_done", d, 1);
        chk("nom_err", e, 0);
        chk("nom_code", o_err_code, 0);
        chk("nom_rca", o_rca, 16'h1234);
        chk("nom_ocr", o_ocr, 32'hC0FF_8000);
        chk("nom_last_addr", last_waddr, 3'd4);
        chk("nom_last_data", last_wdata, PHY_FAST_V);
        chk("nom_xfers", xfer_cnt - b0, 36);
        chk("nom_cmd55", cmd55_cnt - c0, 1);
        chk("nom_phy_slow", slow_cnt - s0, 1);
        chk("nom_phy_fast", fast_cnt - f0, 1);
        @(negedge clk);
        chk("nom_idle", o_busy, 0);
        stall_en = 1'b0;

        // card busy for three ACMD41 rounds
        acmd_busy = 3;
        b0 = xfer_cnt; c0 = cmd55_cnt; a0 = acmd41_cnt;
        run(1'b0, d, e);
        chk("a41_done", d, 1);
        chk("a41_cmd55", cmd55_cnt - c0, 4);
        chk("a41_acmd41", acmd41_cnt - a0, 4);
        chk("a41_xfers", xfer_cnt - b0, 66);
        chk("a41_ocr31", o_ocr[31], 1);

        // card never ready
        acmd_busy = 100;
        a0 = acmd41_cnt;
        run(1'b0, d, e);
        chk("nrdy_err", e, 1);
        chk("nrdy_code", o_err_code, 4'h5);
        chk("nrdy_acmd41", acmd41_cnt - a0, 6);
        chk("nrdy_rca_hold", o_rca, 16'h1234);
        acmd_busy = 0;

        // bad CMD8 echo
        echo = 12'h0AA;
        run(1'b0, d, e);
        chk("echo_err", e, 1);
        chk("echo_code", o_err_code, 4'h4);
        echo = 12'h1AA;

        // card publishes RCA 0
        card_rca = 16'h0;
        run(1'b0, d, e);
        chk("rca0_err", e, 1);
        chk("rca0_code", o_err_code, 4'h6);
        chk("rca0_rca", o_rca, 16'h0);
        card_rca = 16'h1234;

        // v1 card: CMD8 error, echo ignored
        v1_card = 1'b1;
        echo    = 12'h0AA;
        run(1'b0, d, e);
        chk("v1_done", d, 1);
        chk("v1_code", o_err_code, 0);
        chk("v1_rca", o_rca, 16'h1234);
        v1_card = 1'b0;
        echo    = 12'h1AA;

        // no card: CMD8 never leaves busy
        card_absent = 1'b1;
        run(1'b0, d, e);
        chk("nocard_err", e, 1);
        chk("nocard_code", o_err_code, 4'h2);
        chk("nocard_idx", cur_idx, 6'd8);
        @(negedge clk);
        chk("nocard_idle", o_busy, 0);
        card_absent = 1'b0;

        // bus error on the fifth transfer
        err_at = xfer_cnt + 5;
        b0 = xfer_cnt;
        run(1'b0, d, e);
        chk("wberr_err", e, 1);
        chk("wberr_code", o_err_code, 4'h1);
        chk("wberr_cyc", bus.cyc, 0);
        chk("wberr_xfers", xfer_cnt - b0, 5);
        err_at = 0;

        // reset during the first CMD0 poll
        busy_polls = 3;
        b0 = xfer_cnt;
        n  = 0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        while (xfer_cnt - b0 < 4 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_bound", n < 500, 1);
        chk("mid_cyc_before", bus.cyc, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_cyc", bus.cyc, 0);
        chk("mid_busy", o_busy, 0);
        chk("mid_rca", o_rca, 0);
        chk("mid_ocr", o_ocr, 0);
        reset      = 1'b1;
        busy_polls = 1;

        // start pulses while busy are dropped
        d0 = done_cnt;
        run(1'b1, d, e);
        chk("rerun_done", d, 1);
        chk("rerun_rca", o_rca, 16'h1234);
        repeat (30) @(negedge clk);
        chk("rerun_one_done", done_cnt - d0, 1);
        chk("rerun_idle", o_busy, 0);
        chk("stb_without_cyc", stb_no_cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
